vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_TOTAL, 800, clocks per line
- V_TOTAL, 525, lines per frame
- H_VISIBLE_AREA, 640, visible columns
- V_VISIBLE_AREA, 480, visible rows
- H_FRONT_PORCH, 18, clocks from last visible column to HSync fall
- V_FRONT_PORCH, 10, lines from last visible row to VSync fall
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- i_Clk, in, 1, single clock
- i_Reset, in, 1, asynchronous, active-high reset
- i_HSync, in, 1, active-low horizontal sync
- i_VSync, in, 1, active-low vertical sync
- i_Red, in, 1, red pixel bit
- i_Grn, in, 1, green pixel bit
- i_Blu, in, 1, blue pixel bit
- o_Col, out, 10, recovered column
- o_Row, out, 10, recovered row
- o_Pixel_RGB, out, 3, {R,G,B} aligned to o_Col/o_Row
- o_Pixel_Valid, out, 1, visible pixel and locked
- o_Frame_Start, out, 1, one-cycle pulse at (0,0) while locked
- o_Locked, out, 1, timing lock
- o_Error, out, 1, sticky timing error
- o_Frame_Count, out, 8, locked frame counter

Function
REQ-003 Sync and RGB inputs SHALL be registered once; a second HSync/VSync register SHALL provide falling-edge detection (fall = current 0, previous 1).
REQ-004 The H counter SHALL load H_VISIBLE_AREA+H_FRONT_PORCH on an HSync fall, otherwise increment modulo H_TOTAL.
REQ-005 The V counter SHALL advance modulo V_TOTAL only on the cycle the H counter wraps H_TOTAL-1 to 0.
REQ-006 A VSync fall SHALL load the V counter with V_VISIBLE_AREA+V_FRONT_PORCH; the load has priority over a simultaneous advance.
REQ-007 Outputs at cycle n+2 SHALL describe the inputs sampled at edge n; o_Pixel_RGB SHALL be delayed to match.
REQ-008 o_Col and o_Row SHALL equal the H and V counters.
REQ-009 o_Pixel_Valid SHALL be 1 when o_Locked=1, H<H_VISIBLE_AREA and V<V_VISIBLE_AREA.
REQ-010 The state machine SHALL have states SEARCH, H_ACQ, V_ACQ and LOCKED, with these transitions:
- SEARCH to H_ACQ on an HSync fall
- H_ACQ to V_ACQ on a VSync fall
- V_ACQ to LOCKED on the next VSync fall, if no check has failed
- any check failure in H_ACQ, V_ACQ or LOCKED to SEARCH
REQ-011 The H check (active in H_ACQ, V_ACQ and LOCKED) SHALL fail when either holds:
- an HSync fall occurs and the free-running next H value is not H_VISIBLE_AREA+H_FRONT_PORCH (early or late)
- no fall occurs and the next value equals H_VISIBLE_AREA+H_FRONT_PORCH (missing sync)
REQ-012 The V check (active in V_ACQ and LOCKED) SHALL apply the same rule to V at line-advance or VSync-fall cycles.
REQ-013 The counters SHALL still take their load or advance on the failing cycle.
REQ-014 o_Locked SHALL be 1 in LOCKED only; it falls on the cycle after a failure.
REQ-015 o_Error SHALL be set by a check failure in LOCKED and held until reset; failures during acquisition SHALL NOT set it.
REQ-016 o_Frame_Count SHALL increment, wrapping 255 to 0, on each VSync fall that leaves the state in LOCKED, including the locking fall.
REQ-017 o_Frame_Start SHALL pulse for exactly one cycle when the registered H=0, V=0 and LOCKED.

Reset
REQ-018 i_Reset SHALL force the following asynchronously:
- counters, o_Col, o_Row, o_Pixel_RGB, o_Frame_Count = 0
- state = SEARCH
- o_Locked, o_Error, o_Pixel_Valid, o_Frame_Start = 0
REQ-019 While reset is asserted, the sync registers SHALL be 1 so that reset release never produces a false edge.
REQ-020 Reset mid-frame SHALL discard lock; reacquisition SHALL require a full H_ACQ/V_ACQ sequence.

Verification
REQ-021 Two ideal default frames after reset -> o_Locked=1 two cycles after the 2nd VSync fall; o_Error=0.
REQ-022 Locked stream, active pixel -> o_Col steps 0..639 with o_Pixel_Valid=1; o_Col 640..799 with o_Pixel_Valid=0.
REQ-022 (cont.) Locked stream, frame start -> o_Frame_Start pulses once per 420000 cycles.
REQ-023 RGB = {col[2],col[1],col[0]} -> o_Pixel_RGB equals o_Col[2:0] on every valid cycle.
REQ-024 Locked, one HSync fall 1 cycle early -> o_Locked=0 and o_Error=1 within 3 cycles; o_Locked=1 again after two clean VSync falls; o_Error stays 1.
REQ-025 Locked, one HSync pulse omitted -> o_Error=1 three cycles after the missing position.
REQ-025 (cont.) Separate case: reset at row 200 -> all outputs 0 immediately.
REQ-026 Reduced parameters (H_TOTAL=20, V_TOTAL=10) -> o_Frame_Count wraps 255 to 0 with o_Locked held at 1.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// vga_sync_decoder
//
// Recovers pixel coordinates from an incoming VGA-style stream (active-low
// HSync/VSync plus 1-bit R/G/B) and tracks whether the stream timing matches
// the configured geometry.
//
// Pipeline (edge n = edge that samples the pins):
//   edge n   : sync and RGB pins registered
//   edge n+1 : edge detect -> H/V counters, lock FSM, frame counter
//   edge n+2 : all outputs registered together, so every output describes
//              the pins sampled at edge n
//
// Ports
//   i_Clk, i_Reset         : clock, asynchronous active-high reset
//   i_HSync, i_VSync       : active-low sync inputs
//   i_Red, i_Grn, i_Blu    : pixel colour bits
//   o_Col, o_Row           : recovered column / row
//   o_Pixel_RGB            : {R,G,B} aligned with o_Col / o_Row
//   o_Pixel_Valid          : visible area while locked
//   o_Frame_Start          : one-cycle pulse at (0,0) while locked
//   o_Locked               : timing lock
//   o_Error                : sticky, set by a timing failure while locked
//   o_Frame_Count          : count of VSync falls ending in LOCKED (mod 256)
// -----------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int H_TOTAL        = 800,
  parameter int V_TOTAL        = 525,
  parameter int H_VISIBLE_AREA = 640,
  parameter int V_VISIBLE_AREA = 480,
  parameter int H_FRONT_PORCH  = 18,
  parameter int V_FRONT_PORCH  = 10
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_HSync,
  input  logic       i_VSync,
  input  logic       i_Red,
  input  logic       i_Grn,
  input  logic       i_Blu,
  output logic [9:0] o_Col,
  output logic [9:0] o_Row,
  output logic [2:0] o_Pixel_RGB,
  output logic       o_Pixel_Valid,
  output logic       o_Frame_Start,
  output logic       o_Locked,
  output logic       o_Error,
  output logic [7:0] o_Frame_Count
);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_H_ACQ  = 2'd1;
  localparam logic [1:0] S_V_ACQ  = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  // Counter value that the sync fall corresponds to (first column/row after
  // the front porch).
  localparam logic [9:0] H_LOAD = 10'(H_VISIBLE_AREA + H_FRONT_PORCH);
  localparam logic [9:0] V_LOAD = 10'(V_VISIBLE_AREA + V_FRONT_PORCH);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE_AREA);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE_AREA);

  logic       r_hs, r_vs, r_hs_d, r_vs_d;
  logic [2:0] r_rgb, r_rgb_d;
  logic [9:0] r_h_cnt, r_v_cnt;
  logic [1:0] r_state;
  logic [7:0] r_frame_cnt;
  logic       r_lock_fail;

  logic       w_h_fall, w_v_fall;
  logic       w_line_adv;
  logic [9:0] w_h_next_free, w_v_next_free;
  logic       w_h_fail, w_v_fail, w_fail;
  logic [1:0] w_state_next;

  // ---------------------------------------------------------------------------
  // Input stage. Sync registers sit at 1 (idle) during reset so that the first
  // sample after release cannot look like a falling edge.
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from pre-edge values; blocking here would collapse pipeline stages.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_hs_d  <= 1'b1;
      r_vs_d  <= 1'b1;
      r_rgb   <= 3'd0;
      r_rgb_d <= 3'd0;
    end else begin
      r_hs    <= i_HSync;
      r_vs    <= i_VSync;
      r_hs_d  <= r_hs;
      r_vs_d  <= r_vs;
      r_rgb   <= {i_Red, i_Grn, i_Blu};
      r_rgb_d <= r_rgb;
    end
  end

  assign w_h_fall = ~r_hs & r_hs_d;
  assign w_v_fall = ~r_vs & r_vs_d;

  // Free-running successors: what the counters would hold with no sync load.
  assign w_h_next_free = (r_h_cnt == H_LAST) ? 10'd0 : r_h_cnt + 10'd1;
  // A line advances only on a genuine H wrap, not when an HSync load wins.
  assign w_line_adv    = (r_h_cnt == H_LAST) & ~w_h_fall;
  assign w_v_next_free = !w_line_adv       ? r_v_cnt :
                         (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;

  // A sync fall must land exactly where the free-running counter expects it,
  // and the counter must not reach that point without one.
  assign w_h_fail = (r_state != S_SEARCH) &
                    (w_h_fall ? (w_h_next_free != H_LOAD)
                              : (w_h_next_free == H_LOAD));
  assign w_v_fail = ((r_state == S_V_ACQ) | (r_state == S_LOCKED)) &
                    (w_v_fall ? (w_v_next_free != V_LOAD)
                              : (w_line_adv & (w_v_next_free == V_LOAD)));
  assign w_fail   = w_h_fail | w_v_fail;

  // NOTE: the default assignment up front keeps this combinational block from
  // inferring a latch on paths that do not change state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_SEARCH: if (w_h_fall) w_state_next = S_H_ACQ;
      S_H_ACQ:  if (w_fail)   w_state_next = S_SEARCH;
                else if (w_v_fall) w_state_next = S_V_ACQ;
      S_V_ACQ:  if (w_fail)   w_state_next = S_SEARCH;
                else if (w_v_fall) w_state_next = S_LOCKED;
      default:  if (w_fail)   w_state_next = S_SEARCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters and lock FSM. Counters load/advance even on a failing cycle so
  // the next acquisition starts from the freshest sync position.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_h_cnt     <= 10'd0;
      r_v_cnt     <= 10'd0;
      r_state     <= S_SEARCH;
      r_frame_cnt <= 8'd0;
      r_lock_fail <= 1'b0;
    end else begin
      r_h_cnt <= w_h_fall ? H_LOAD : w_h_next_free;
      if (w_v_fall) begin
        r_v_cnt <= V_LOAD;
      end else if (w_line_adv) begin
        r_v_cnt <= w_v_next_free;
      end
      r_state     <= w_state_next;
      // Includes the fall that moves V_ACQ into LOCKED.
      if (w_v_fall && (w_state_next == S_LOCKED)) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      // Only failures seen while locked count as stream errors.
      r_lock_fail <= (r_state == S_LOCKED) & w_fail;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: one register layer so everything lines up at edge n+2.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Col         <= 10'd0;
      o_Row         <= 10'd0;
      o_Pixel_RGB   <= 3'd0;
      o_Pixel_Valid <= 1'b0;
      o_Frame_Start <= 1'b0;
      o_Locked      <= 1'b0;
      o_Error       <= 1'b0;
      o_Frame_Count <= 8'd0;
    end else begin
      o_Col         <= r_h_cnt;
      o_Row         <= r_v_cnt;
      o_Pixel_RGB   <= r_rgb_d;
      o_Pixel_Valid <= (r_state == S_LOCKED) & (r_h_cnt < H_VIS) & (r_v_cnt < V_VIS);
      o_Frame_Start <= (r_state == S_LOCKED) & (r_h_cnt == 10'd0) & (r_v_cnt == 10'd0);
      o_Locked      <= (r_state == S_LOCKED);
      o_Error       <= o_Error | r_lock_fail;
      o_Frame_Count <= r_frame_cnt;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_decoder
//
// Directed bench for vga_sync_decoder using a small geometry (20x10 total,
// 12x6 visible, porches 2/1) so whole frames are cheap. A stimulus generator
// walks (gh,gv) one position per clock; HSync is low for gh in [14,17), VSync
// low for gv in [7,9); RGB carries gh[2:0]. Outputs are sampled 1 time unit
// after each rising edge; after the edge that samples position p, the
// coordinate outputs describe position p-2.
// -----------------------------------------------------------------------------
module tb_vga_sync_decoder;

  localparam int HT = 20;
  localparam int VT = 10;
  localparam int HV = 12;
  localparam int VV = 6;
  localparam int HS_BEG = 14;  // 12 + 2
  localparam int HS_END = 17;
  localparam int VS_BEG = 7;   // 6 + 1
  localparam int VS_END = 9;

  logic       i_Clk = 1'b0;
  logic       i_Reset;
  logic       i_HSync, i_VSync, i_Red, i_Grn, i_Blu;
  logic [9:0] o_Col, o_Row;
  logic [2:0] o_Pixel_RGB;
  logic       o_Pixel_Valid, o_Frame_Start, o_Locked, o_Error;
  logic [7:0] o_Frame_Count;

  int checks = 0;
  int errors = 0;

  int gh = 0, gv = 0;                 // position driven next
  int s_h0, s_h1, s_h2, s_v0, s_v1, s_v2;  // positions sampled at last 3 edges
  bit early_en = 1'b0;                // HSync fall at h=13 on line 2
  bit omit_en  = 1'b0;                // no HSync pulse on line 3

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_VISIBLE_AREA(HV), .V_VISIBLE_AREA(VV),
    .H_FRONT_PORCH(2), .V_FRONT_PORCH(1)
  ) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_HSync(i_HSync), .i_VSync(i_VSync),
    .i_Red(i_Red), .i_Grn(i_Grn), .i_Blu(i_Blu),
    .o_Col(o_Col), .o_Row(o_Row), .o_Pixel_RGB(o_Pixel_RGB),
    .o_Pixel_Valid(o_Pixel_Valid), .o_Frame_Start(o_Frame_Start),
    .o_Locked(o_Locked), .o_Error(o_Error), .o_Frame_Count(o_Frame_Count)
  );

  always #5 i_Clk = ~i_Clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic hs;
    hs = !(gh >= HS_BEG && gh < HS_END);
    if (early_en && gv == 2 && gh == 13) hs = 1'b0;
    if (omit_en && gv == 3) hs = 1'b1;
    i_HSync = hs;
    i_VSync = !(gv >= VS_BEG && gv < VS_END);
    i_Red   = gh[2];
    i_Grn   = gh[1];
    i_Blu   = gh[0];
  endtask

  task automatic tick();
    drive();
    @(posedge i_Clk);
    #1;
    s_h2 = s_h1; s_v2 = s_v1;
    s_h1 = s_h0; s_v1 = s_v0;
    s_h0 = gh;   s_v0 = gv;
    if (gh == HT - 1) begin
      gh = 0;
      gv = (gv == VT - 1) ? 0 : gv + 1;
    end else begin
      gh++;
    end
  endtask

  // Tick until (th,tv) is the next position to be sampled.
  task automatic advance_to(input int th, input int tv);
    int n;
    n = 0;
    while (!(gh == th && gv == tv) && n < 1000) begin
      tick();
      n++;
    end
    if (!(gh == th && gv == tv)) begin
      checks++;
      errors++;
      $display("FAIL advance_to(%0d,%0d): position not reached", th, tv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_col"},   32'(o_Col), 0);
    check({tag, "_row"},   32'(o_Row), 0);
    check({tag, "_rgb"},   32'(o_Pixel_RGB), 0);
    check({tag, "_valid"}, 32'(o_Pixel_Valid), 0);
    check({tag, "_fs"},    32'(o_Frame_Start), 0);
    check({tag, "_lock"},  32'(o_Locked), 0);
    check({tag, "_err"},   32'(o_Error), 0);
    check({tag, "_fcnt"},  32'(o_Frame_Count), 0);
  endtask

  // From any point, sample two VSync falls and verify lock appears exactly two
  // edges after the second one.
  task automatic acquire(input string tag);
    advance_to(0, VS_BEG); tick();
    tick(); tick();
    check({tag, "_lock_after_1st_vfall"}, 32'(o_Locked), 0);
    advance_to(0, VS_BEG); tick();
    tick();
    check({tag, "_lock_at_+1"}, 32'(o_Locked), 0);
    tick();
    check({tag, "_lock_at_+2"}, 32'(o_Locked), 1);
  endtask

  initial begin
    int fs_cnt;

    // ---- reset state ----
    i_Reset = 1'b1;
    gh = 0; gv = 0;
    drive();
    repeat (3) @(posedge i_Clk);
    #1;
    check_all_zero("reset");
    i_Reset = 1'b0;

    // ---- acquisition from clean frames ----
    acquire("boot");
    check("boot_fcnt", 32'(o_Frame_Count), 1);
    check("boot_err",  32'(o_Error), 0);

    // ---- one full locked frame, every cycle ----
    fs_cnt = 0;
    for (int i = 0; i < HT * VT; i++) begin
      tick();
      check("col",   32'(o_Col), 32'(s_h2));
      check("row",   32'(o_Row), 32'(s_v2));
      check("valid", 32'(o_Pixel_Valid), 32'(s_h2 < HV && s_v2 < VV));
      check("rgb",   32'(o_Pixel_RGB), 32'(s_h2 % 8));
      check("fs",    32'(o_Frame_Start), 32'(s_h2 == 0 && s_v2 == 0));
      if (o_Frame_Start) fs_cnt++;
    end
    check("fs_per_frame", 32'(fs_cnt), 1);
    check("frame_err", 32'(o_Error), 0);

    // ---- omitted HSync pulse on line 3 ----
    advance_to(14, 3);
    omit_en = 1'b1;
    tick();                       // samples the missing fall position
    tick();
    check("omit_+1_err",  32'(o_Error), 0);
    check("omit_+1_lock", 32'(o_Locked), 1);
    tick();
    check("omit_+2_err",  32'(o_Error), 1);
    check("omit_+2_lock", 32'(o_Locked), 0);
    advance_to(0, 4);
    omit_en = 1'b0;
    acquire("omit_relock");
    check("omit_relock_err", 32'(o_Error), 1);

    // ---- reset mid-frame while locked ----
    advance_to(2, 3);
    check("pre_reset_lock", 32'(o_Locked), 1);
    i_Reset = 1'b1;
    #1;
    check_all_zero("midreset");
    tick(); tick(); tick();
    i_Reset = 1'b0;               // released at h=5, HSync high
    tick(); tick();
    check("post_reset_lock", 32'(o_Locked), 0);
    acquire("reacq");
    check("reacq_fcnt", 32'(o_Frame_Count), 1);
    check("reacq_err",  32'(o_Error), 0);

    // ---- HSync fall one cycle early on line 2 ----
    advance_to(13, 2);
    early_en = 1'b1;
    tick();                       // samples the early fall
    early_en = 1'b0;
    tick();
    check("early_+1_lock", 32'(o_Locked), 1);
    check("early_+1_err",  32'(o_Error), 0);
    tick();
    check("early_+2_lock", 32'(o_Locked), 0);
    check("early_+2_err",  32'(o_Error), 1);
    acquire("early_relock");
    check("early_relock_err", 32'(o_Error), 1);

    // ---- frame counter wrap with lock held ----
    i_Reset = 1'b1;
    gh = 0; gv = 0;
    tick(); tick();
    i_Reset = 1'b0;
    acquire("wrap");
    check("wrap_fcnt_start", 32'(o_Frame_Count), 1);
    for (int k = 1; k <= 255; k++) begin
      advance_to(0, VS_BEG);
      tick(); tick(); tick();
      check("wrap_lock", 32'(o_Locked), 1);
      check("wrap_fcnt", 32'(o_Frame_Count), 32'((1 + k) % 256));
    end
    check("wrap_err", 32'(o_Error), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
